// File: rtl/comp_stream.sv
// Two-stage, stallable multi-lane magnitude comparator with a valid/ready stream
// interface, runtime signed/unsigned mode and saturating transfer statistics.
module comp_stream #(
  parameter int DATAWIDTH = 32,
  parameter int LANES     = 4,
  parameter int CNTWIDTH  = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATAWIDTH-1:0] a,
  input  logic [LANES*DATAWIDTH-1:0] b,
  input  logic                       is_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           gt,
  output logic [LANES-1:0]           lt,
  output logic [LANES-1:0]           eq,
  output logic                       all_eq,
  output logic                       any_gt,
  input  logic                       clr,
  output logic [CNTWIDTH-1:0]        xfer_cnt,
  output logic [CNTWIDTH-1:0]        match_cnt
);

  localparam int VW = LANES * DATAWIDTH;
  localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [2:0] lane_cmp(input logic [DATAWIDTH-1:0] x,
                                          input logic [DATAWIDTH-1:0] y,
                                          input logic             sgn);
    logic [DATAWIDTH-1:0] xb;
    logic [DATAWIDTH-1:0] yb;
    xb = x;
    yb = y;
    if (sgn) begin
      xb[DATAWIDTH-1] = ~x[DATAWIDTH-1];
      yb[DATAWIDTH-1] = ~y[DATAWIDTH-1];
    end else begin
      xb = x;
      yb = y;
    end
    if (xb > yb) begin
      return 3'b100;
    end else if (xb < yb) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

  logic          r_s1_valid;
  logic [VW-1:0] r_a;
  logic [VW-1:0] r_b;
  logic          r_sgn;

  logic             r_s2_valid;
  logic [LANES-1:0] r_gt;
  logic [LANES-1:0] r_lt;
  logic [LANES-1:0] r_eq;

  logic [CNTWIDTH-1:0] r_xfer_cnt;
  logic [CNTWIDTH-1:0] r_match_cnt;

  logic             w_en1;
  logic             w_en2;
  logic             w_xfer;
  logic             w_all_eq;
  logic [LANES-1:0] w_gt;
  logic [LANES-1:0] w_lt;
  logic [LANES-1:0] w_eq;

  assign w_en2    = !r_s2_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign w_xfer   = r_s2_valid && out_ready;
  assign w_all_eq = &r_eq;

  assign in_ready  = w_en1;
  assign out_valid = r_s2_valid;
  assign gt        = r_gt;
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign all_eq    = w_all_eq;
  assign any_gt    = |r_gt;
  assign xfer_cnt  = r_xfer_cnt;
  assign match_cnt = r_match_cnt;

  // Per-lane compare of the stage-1 operands.
  always_comb begin
    logic [2:0] w_res;
    w_gt  = '0;
    w_lt  = '0;
    w_eq  = '0;
    w_res = 3'b000;
    for (int i = 0; i < LANES; i++) begin
      w_res   = lane_cmp(r_a[i*DATAWIDTH +: DATAWIDTH], r_b[i*DATAWIDTH +: DATAWIDTH], r_sgn);
      w_gt[i] = w_res[2];
      w_lt[i] = w_res[1];
      w_eq[i] = w_res[0];
    end
  end

  // Stage 1: capture operands and mode on accept; a bubble only clears valid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sgn      <= 1'b0;
    end else if (w_en1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_sgn <= is_signed;
      end else begin
        r_a   <= r_a;
        r_b   <= r_b;
        r_sgn <= r_sgn;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage 2: register the flags; they hold through bubbles and stalls.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s2_valid <= 1'b0;
      r_gt       <= '0;
      r_lt       <= '0;
      r_eq       <= '0;
    end else if (w_en2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_gt <= w_gt;
        r_lt <= w_lt;
        r_eq <= w_eq;
      end else begin
        r_gt <= r_gt;
        r_lt <= r_lt;
        r_eq <= r_eq;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  // Saturating statistics; clr wins over a same-cycle increment.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_xfer_cnt  <= '0;
      r_match_cnt <= '0;
    end else if (clr) begin
      r_xfer_cnt  <= '0;
      r_match_cnt <= '0;
    end else if (w_xfer) begin
      if (&r_xfer_cnt) begin
        r_xfer_cnt <= r_xfer_cnt;
      end else begin
        r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
      end
      if (w_all_eq && !(&r_match_cnt)) begin
        r_match_cnt <= r_match_cnt + CNT_ONE;
      end else begin
        r_match_cnt <= r_match_cnt;
      end
    end else begin
      r_xfer_cnt  <= r_xfer_cnt;
      r_match_cnt <= r_match_cnt;
    end
  end

endmodule

// File: tb/tb_comp_stream.sv
// Directed bench for comp_stream with DATAWIDTH=8, LANES=2, CNTWIDTH=4.
module tb_comp_stream;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  gt;
  logic [1:0]  lt;
  logic [1:0]  eq;
  logic        all_eq;
  logic        any_gt;
  logic        clr;
  logic [3:0]  xfer_cnt;
  logic [3:0]  match_cnt;

  int n_cmp;
  int n_err;

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vs [8];
  logic [7:0]  vexp [8];
  logic [5:0]  bp_exp [5];

  comp_stream #(.DATAWIDTH(8), .LANES(2), .CNTWIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .gt(gt), .lt(lt), .eq(eq), .all_eq(all_eq),
    .any_gt(any_gt), .clr(clr), .xfer_cnt(xfer_cnt), .match_cnt(match_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Streams n vectors at full rate and checks each result in order.
  task automatic run_vectors(input int n, input string tag);
    int nout;
    int first;
    int last;
    nout  = 0;
    first = -1;
    last  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < n + 6; c++) begin
      in_valid = (c < n);
      if (c < n) begin
        a = va[c];
        b = vb[c];
        is_signed = vs[c];
      end
      #1;
      if (out_valid) begin
        if (nout < n) chk({tag, "_res"}, {gt, lt, eq, all_eq, any_gt}, vexp[nout]);
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, nout, n);
    chk({tag, "_first"}, first, 2);
    chk({tag, "_span"}, last - first + 1, n);
  endtask

  initial begin
    int k_in;
    int k_out;
    int bp_cycles;
    n_cmp = 0; n_err = 0;
    Rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    out_ready = 1'b0; clr = 1'b0;
    bp_exp[0] = 6'b00_01_10;
    bp_exp[1] = 6'b10_01_00;
    bp_exp[2] = 6'b10_00_01;
    bp_exp[3] = 6'b11_00_00;
    bp_exp[4] = 6'b11_00_00;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_all_eq", all_eq, 0);
    chk("rst_any_gt", any_gt, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_match", match_cnt, 0);
    #1 Rst = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    @(posedge Clk); #1;

    // Single beat: lane0 05 vs 05, lane1 10 vs 20
    a = {8'h10, 8'h05}; b = {8'h20, 8'h05}; is_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk("t1_lat1_valid", out_valid, 0);
    @(posedge Clk); #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_flags", {gt, lt, eq}, 6'b00_10_01);
    chk("t1_all_eq", all_eq, 0);
    chk("t1_any_gt", any_gt, 0);
    @(posedge Clk); #1;
    chk("t1_xfer", xfer_cnt, 1);
    chk("t1_match", match_cnt, 0);
    chk("t1_drained", out_valid, 0);

    // Signed vs unsigned on 0x80 vs 0x01
    va[0] = 16'h8080; vb[0] = 16'h0101; vs[0] = 1'b0; vexp[0] = 8'b11_00_00_0_1;
    va[1] = 16'h8080; vb[1] = 16'h0101; vs[1] = 1'b1; vexp[1] = 8'b00_11_00_0_0;
    run_vectors(2, "sgn");
    chk("sgn_xfer", xfer_cnt, 3);

    // Backpressure: fill with out_ready low, then release
    out_ready = 1'b0; k_in = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      a = {8'(8'h10 + k_in), 8'(k_in)}; b = {8'h10, 8'h02}; is_signed = 1'b0;
      #1;
      if (in_ready) k_in++;
      @(posedge Clk); #1;
    end
    a = {8'(8'h10 + k_in), 8'(k_in)};
    #1;
    chk("bp_accepts", k_in, 2);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1 chk("bp_ready_comb", in_ready, 1);
    k_out = 0; bp_cycles = 0;
    for (int c = 0; c < 12 && k_out < 5; c++) begin
      in_valid = (k_in < 5);
      a = {8'(8'h10 + k_in), 8'(k_in)};
      #1;
      if (out_valid) begin
        chk("bp_res", {gt, lt, eq}, bp_exp[k_out]);
        k_out++;
      end
      if (in_valid && in_ready) k_in++;
      bp_cycles++;
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_outputs", k_out, 5);
    chk("bp_cycles", bp_cycles, 5);
    chk("bp_xfer", xfer_cnt, 8);
    chk("bp_empty", out_valid, 0);

    // Reset mid-flight with two beats in the pipe
    out_ready = 1'b0;
    a = 16'h4242; b = 16'h4242; in_valid = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_eq", all_eq, 1);
    #2 Rst = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_all_eq", all_eq, 0);
    chk("mid_in_ready", in_ready, 1);
    #2 Rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      chk("mid_post_valid", out_valid, 0);
    end
    chk("mid_xfer", xfer_cnt, 0);
    chk("mid_match", match_cnt, 0);

    // Boundary values
    va[0] = 16'h7F7F; vb[0] = 16'h8080; vs[0] = 1'b0; vexp[0] = 8'b00_11_00_0_0;
    va[1] = 16'h7F7F; vb[1] = 16'h8080; vs[1] = 1'b1; vexp[1] = 8'b11_00_00_0_1;
    va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vs[2] = 1'b0; vexp[2] = 8'b00_00_11_1_0;
    va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vs[3] = 1'b1; vexp[3] = 8'b00_00_11_1_0;
    run_vectors(4, "bnd");
    chk("bnd_xfer", xfer_cnt, 4);
    chk("bnd_match", match_cnt, 2);

    // Saturation with 20 equal beats
    out_ready = 1'b1;
    a = 16'h3333; b = 16'h3333; is_signed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk("sat_xfer", xfer_cnt, 15);
    chk("sat_match", match_cnt, 15);

    // clr coinciding with an output transfer
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5 && !out_valid; c++) begin
      @(posedge Clk); #1;
    end
    chk("clr_xfer_cycle", out_valid && out_ready, 1);
    clr = 1'b1;
    @(posedge Clk); #1;
    clr = 1'b0;
    chk("clr_xfer", xfer_cnt, 0);
    chk("clr_match", match_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
